// File: rtl/trailer_gen_if.sv
// Trailer word stream: valid/data from the generator, ready from downstream.
interface trailer_gen_if #(
  parameter int DATA_WD = 32
);
  logic               o_data_valid;
  logic [DATA_WD-1:0] ov_data;
  logic               i_ready;

  modport master (
    output o_data_valid,
    output ov_data,
    input  i_ready
  );

  modport slave (
    input  o_data_valid,
    input  ov_data,
    output i_ready
  );
endinterface

// File: rtl/trailer_gen.sv
// U3V trailer generator: 8 words, or 9 with chunk layout ID.
// Optional 9th word enabled by macro TRAILER_CHUNK_LAYOUT_EN.
module trailer_gen #(
  parameter int DATA_WD      = 32,
  parameter int SHORT_REG_WD = 16,
  parameter int REG_WD       = 32,
  parameter int LONG_REG_WD  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_stream_enable,
  input  logic                    i_trailer_start,
  input  logic                    i_chunk_mode_active,
  input  logic [LONG_REG_WD-1:0]  iv_blockid,
  input  logic [SHORT_REG_WD-1:0] iv_status,
  input  logic [REG_WD-1:0]       iv_valid_payload_size,
  input  logic [REG_WD-1:0]       iv_size_y,
  input  logic [REG_WD-1:0]       iv_chunk_layout_id,
  trailer_gen_if.master           tx,
  output logic                    o_trailer_done
);

  localparam logic [31:0] MAGIC = 32'h54563355;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t                  state;
  logic [3:0]              idx;
  logic [3:0]              nxt_idx;
  logic [3:0]              last_idx;
  logic                    chunk_q;
  logic [LONG_REG_WD-1:0]  blockid_q;
  logic [SHORT_REG_WD-1:0] status_q;
  logic [REG_WD-1:0]       vps_q;
  logic [REG_WD-1:0]       size_y_q;
  logic [REG_WD-1:0]       layout_q;
  logic [15:0]             trl_size;
  logic [DATA_WD-1:0]      nxt_word;
  logic                    accept;

`ifdef TRAILER_CHUNK_LAYOUT_EN
  assign last_idx = chunk_q ? 4'd8 : 4'd7;
`else
  logic unused_ok;
  assign unused_ok = chunk_q;
  assign last_idx  = 4'd7;
`endif

  assign accept   = tx.o_data_valid & tx.i_ready;
  assign nxt_idx  = idx + 4'd1;
  assign trl_size = (last_idx == 4'd8) ? 16'h0024
                                       : 16'h0020;

  // Word shown after the current one is accepted.
  always_comb begin
    nxt_word = '0;
    case (nxt_idx)
      4'd1: nxt_word = DATA_WD'({trl_size, 16'h0000});
      4'd2: nxt_word = DATA_WD'(blockid_q[31:0]);
      4'd3: nxt_word = DATA_WD'(blockid_q[63:32]);
      4'd4: nxt_word = DATA_WD'({16'h0000, status_q});
      4'd5: nxt_word = DATA_WD'(vps_q);
      4'd7: nxt_word = DATA_WD'(size_y_q);
      4'd8: nxt_word = DATA_WD'(layout_q);
      default: nxt_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= '0;
      chunk_q         <= 1'b0;
      blockid_q       <= '0;
      status_q        <= '0;
      vps_q           <= '0;
      size_y_q        <= '0;
      layout_q        <= '0;
      tx.o_data_valid <= 1'b0;
      tx.ov_data      <= '0;
      o_trailer_done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          o_trailer_done <= 1'b0;
          if (i_trailer_start && i_stream_enable) begin
            chunk_q         <= i_chunk_mode_active;
            blockid_q       <= iv_blockid;
            status_q        <= iv_status;
            vps_q           <= iv_valid_payload_size;
            size_y_q        <= iv_size_y;
            layout_q        <= iv_chunk_layout_id;
            idx             <= '0;
            tx.o_data_valid <= 1'b1;
            tx.ov_data      <= DATA_WD'(MAGIC);
            state           <= SEND;
          end
        end
        SEND: begin
          if (!i_stream_enable) begin
            idx             <= '0;
            tx.o_data_valid <= 1'b0;
            tx.ov_data      <= '0;
            state           <= IDLE;
          end else if (accept) begin
            if (idx == last_idx) begin
              idx             <= '0;
              tx.o_data_valid <= 1'b0;
              tx.ov_data      <= '0;
              o_trailer_done  <= 1'b1;
              state           <= DONE;
            end else begin
              idx        <= nxt_idx;
              tx.ov_data <= nxt_word;
            end
          end
        end
        DONE: begin
          o_trailer_done <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trailer_gen.sv
// Directed bench for trailer_gen: word order, stalls, abort,
// ignored starts, mid-trailer reset.
module tb_trailer_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic        chunk = 1'b0;
  logic [63:0] blockid = '0;
  logic [15:0] status = '0;
  logic [31:0] vps = '0;
  logic [31:0] size_y = '0;
  logic [31:0] layout = '0;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [31:0] words[$];
  int          done_cnt;
  int          done_cyc;
  int          last_acc;
  int          hold_cnt;
  int          zero_bad;
  logic        snap_valid;
  logic [31:0] snap_data;
  logic        snap_done;

  trailer_gen_if #(.DATA_WD(32)) tx ();

  trailer_gen dut (
    .clk                   (clk),
    .reset                 (reset),
    .i_stream_enable       (en),
    .i_trailer_start       (start),
    .i_chunk_mode_active   (chunk),
    .iv_blockid            (blockid),
    .iv_status             (status),
    .iv_valid_payload_size (vps),
    .iv_size_y             (size_y),
    .iv_chunk_layout_id    (layout),
    .tx                    (tx.master),
    .o_trailer_done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs 24 cycles, recording accepted words and side events.
  task automatic collect(input int stall_at,
                         input int drop_at,
                         input int rst_at,
                         input int poke_at);
    int stalls;
    int act;
    int k;
    stalls = 0;
    act = -1;
    words.delete();
    done_cnt = 0;
    done_cyc = -1;
    last_acc = -1;
    hold_cnt = 0;
    zero_bad = 0;
    snap_valid = 1'bx;
    snap_data = 'x;
    snap_done = 1'bx;
    for (int c = 0; c < 24; c++) begin
      start = 1'b0;
      reset = 1'b0;
      tx.i_ready = 1'b1;
      if (act >= 0 && c == act + 1) begin
        snap_valid = tx.o_data_valid;
        snap_data = tx.ov_data;
        snap_done = done;
      end
      if (!tx.o_data_valid && tx.ov_data != 0)
        zero_bad++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (tx.o_data_valid) begin
        k = words.size();
        if (tx.ov_data == 32'h0000A101) hold_cnt++;
        if (k == stall_at && stalls < 3) begin
          tx.i_ready = 1'b0;
          stalls++;
        end
        if (k == drop_at && act < 0) begin
          en = 1'b0;
          act = c;
        end
        if (k == rst_at && act < 0) begin
          reset = 1'b1;
          act = c;
        end
        if (k == poke_at && act < 0) begin
          start = 1'b1;
          blockid = 64'hDEAD_BEEF_CAFE_F00D;
          status = 16'h1234;
          vps = 32'h0BAD_0BAD;
          act = c;
        end
        if (tx.i_ready && !reset) begin
          words.push_back(tx.ov_data);
          last_acc = c;
        end
      end
      step();
    end
    start = 1'b0;
    reset = 1'b0;
    tx.i_ready = 1'b1;
  endtask

  task automatic check_words(input string tag,
                             input int n,
                             input logic [63:0] b,
                             input logic [15:0] s,
                             input logic [31:0] v,
                             input logic [31:0] y,
                             input logic [31:0] l);
    logic [31:0] e[9];
    e[0] = 32'h54563355;
    e[1] = (n == 9) ? 32'h00240000 : 32'h00200000;
    e[2] = b[31:0];
    e[3] = b[63:32];
    e[4] = {16'h0000, s};
    e[5] = v;
    e[6] = 32'h0;
    e[7] = y;
    e[8] = l;
    chk({tag, "_count"}, words.size(), n);
    for (int i = 0; i < n && i < words.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), words[i], e[i]);
  endtask

  initial begin
    tx.i_ready = 1'b1;
    step();
    step();
    chk("rst_valid", tx.o_data_valid, 1'b0);
    chk("rst_data", tx.ov_data, 32'h0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;
    step();

    // start while stream disabled is dropped
    kick();
    chk("dis_valid0", tx.o_data_valid, 1'b0);
    step();
    chk("dis_valid1", tx.o_data_valid, 1'b0);

    // basic 8-word trailer, hand-computed words
    en = 1'b1;
    blockid = 64'h0000_0001_0000_0005;
    status = 16'h0000;
    vps = 32'h0010_0000;
    size_y = 32'h0000_0400;
    layout = 32'h0000_0003;
    kick();
    collect(-1, -1, -1, -1);
    chk("t1_count", words.size(), 8);
    if (words.size() == 8) begin
      chk("t1_w0", words[0], 32'h54563355);
      chk("t1_w1", words[1], 32'h00200000);
      chk("t1_w2", words[2], 32'h00000005);
      chk("t1_w3", words[3], 32'h00000001);
      chk("t1_w4", words[4], 32'h00000000);
      chk("t1_w5", words[5], 32'h00100000);
      chk("t1_w6", words[6], 32'h00000000);
      chk("t1_w7", words[7], 32'h00000400);
    end
    chk("t1_last", last_acc, 7);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_cyc", done_cyc, 8);
    chk("t1_zero", zero_bad, 0);

    // chunk mode: 9 words only when the option is built in
    chunk = 1'b1;
    kick();
    collect(-1, -1, -1, -1);
`ifdef TRAILER_CHUNK_LAYOUT_EN
    check_words("t2", 9, blockid, status, vps, size_y, layout);
    chk("t2_done_cyc", done_cyc, 9);
`else
    check_words("t2", 8, blockid, status, vps, size_y, layout);
    chk("t2_done_cyc", done_cyc, 8);
`endif
    chk("t2_done_cnt", done_cnt, 1);
    chunk = 1'b0;

    // 3-cycle stall on w4
    status = 16'hA101;
    kick();
    collect(4, -1, -1, -1);
    check_words("t3", 8, blockid, 16'hA101, vps, size_y, layout);
    chk("t3_hold", hold_cnt, 4);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_done_cyc", done_cyc, 11);
    chk("t3_zero", zero_bad, 0);
    status = 16'h0000;

    // stream disabled while w3 is shown
    kick();
    collect(-1, 3, -1, -1);
    chk("t4_count", words.size(), 4);
    chk("t4_valid", snap_valid, 1'b0);
    chk("t4_data", snap_data, 32'h0);
    chk("t4_done_cnt", done_cnt, 0);
    en = 1'b1;
    kick();
    collect(-1, -1, -1, -1);
    check_words("t4r", 8, blockid, status, vps, size_y, layout);
    chk("t4r_done_cnt", done_cnt, 1);

    // second start plus field changes mid-trailer
    blockid = 64'h1122_3344_5566_7788;
    status = 16'hA101;
    vps = 32'h0000_1234;
    kick();
    collect(-1, -1, -1, 2);
    check_words("t5", 8, 64'h1122_3344_5566_7788,
                16'hA101, 32'h0000_1234, size_y, layout);
    chk("t5_done_cnt", done_cnt, 1);

    // synchronous reset while w5 is shown
    blockid = 64'h0000_0001_0000_0005;
    status = 16'h0000;
    vps = 32'h0010_0000;
    kick();
    collect(-1, -1, 5, -1);
    chk("t6_count", words.size(), 5);
    chk("t6_valid", snap_valid, 1'b0);
    chk("t6_data", snap_data, 32'h0);
    chk("t6_done", snap_done, 1'b0);
    chk("t6_done_cnt", done_cnt, 0);
    kick();
    collect(-1, -1, -1, -1);
    check_words("t6r", 8, blockid, status, vps, size_y, layout);
    chk("t6r_done_cnt", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/trailer_gen.md
TRAILER_GEN -- requirements
Module: trailer_gen

Interface
REQ-001 The module SHALL have parameter DATA_WD, default 32, meaning output data word width.
REQ-002 The module SHALL have parameter SHORT_REG_WD, default 16, meaning status register width.
REQ-003 The module SHALL have parameter REG_WD, default 32, meaning register width.
REQ-004 The module SHALL have parameter LONG_REG_WD, default 64, meaning block ID width.
REQ-005 The module SHALL have port clk, input, 1, the single clock.
REQ-006 The module SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 The module SHALL have port i_stream_enable, input, 1, stream enable; low aborts output.
REQ-008 The module SHALL have port i_trailer_start, input, 1, single-cycle request issued after the payload image and chunk data end.
REQ-009 The module SHALL have port i_chunk_mode_active, input, 1, chunk mode.
REQ-010 The module SHALL have port iv_blockid, input, LONG_REG_WD, block ID of the frame.
REQ-011 The module SHALL have port iv_status, input, SHORT_REG_WD, status from the payload stage (0x0000 or 0xA101).
REQ-012 The module SHALL have port iv_valid_payload_size, input, REG_WD, valid payload bytes from the payload stage.
REQ-013 The module SHALL have port iv_size_y, input, REG_WD, image line count.
REQ-014 The module SHALL have port iv_chunk_layout_id, input, REG_WD, chunk layout ID.
REQ-015 The module SHALL have port i_ready, input, 1, downstream accepts the current word.
REQ-016 The module SHALL have port o_data_valid, output, 1, trailer word valid.
REQ-017 The module SHALL have port ov_data, output, DATA_WD, trailer word.
REQ-018 The module SHALL have port o_trailer_done, output, 1, one-cycle pulse after the last word is accepted.

Function
REQ-019 The FSM SHALL have states IDLE, SEND and DONE.
REQ-020 In IDLE, when i_trailer_start=1 and i_stream_enable=1, the module SHALL latch all iv_* fields and i_chunk_mode_active, clear the word index, and enter SEND.
REQ-021 o_data_valid SHALL be high in the cycle after the start pulse and stay high throughout SEND.
REQ-022 A word SHALL be accepted when o_data_valid=1 and i_ready=1; ov_data and the index SHALL hold while i_ready=0.
REQ-023 Word order SHALL be:
 - w0: 0x54563355 ("U3VT")
 - w1: {trailer_size[15:0], 16'h0000}
 - w2: blockid[31:0]
 - w3: blockid[63:32]
 - w4: {16'h0000, status}
 - w5: valid_payload_size
 - w6: 0x00000000
 - w7: size_y
 - w8: chunk_layout_id (only if present, see REQ-034).
REQ-024 Trailer size SHALL be 32 (0x20) for an 8-word trailer and 36 (0x24) for a 9-word trailer.
REQ-025 After the last word is accepted, the FSM SHALL go to DONE with o_data_valid=0 for 1 cycle, then return to IDLE.
REQ-026 o_trailer_done SHALL be 1 exactly during DONE.
REQ-027 i_trailer_start outside IDLE SHALL be ignored.
REQ-028 i_trailer_start in IDLE with i_stream_enable=0 SHALL be ignored.
REQ-029 If i_stream_enable=0 in SEND, the FSM SHALL go to IDLE on the next edge, drop o_data_valid, and not pulse o_trailer_done; an acceptance in that same cycle SHALL still count.
REQ-030 Input changes after the latch SHALL NOT affect the trailer in flight.
REQ-031 ov_data SHALL be 0 whenever o_data_valid=0.

Reset
REQ-032 On reset=1 at a clock edge the FSM SHALL enter IDLE with the index at 0 and latched fields at 0.
REQ-033 On reset, o_data_valid, ov_data and o_trailer_done SHALL be 0; this SHALL also apply to a reset mid-SEND, with no done pulse.

Configuration
REQ-034 With macro TRAILER_CHUNK_LAYOUT_EN defined, a latched chunk mode of 1 SHALL produce 9 words with trailer size 0x24; without it, or with chunk mode 0, the trailer SHALL be 8 words with trailer size 0x20 and iv_chunk_layout_id ignored.

Verification
REQ-035 Start with chunk=0, blockid=0x0000000100000005, status=0, size=0x100000, size_y=0x400, and i_ready=1 -> 8 consecutive words 0x54563355, 0x00200000, 0x00000005, 0x00000001, 0x00000000, 0x00100000, 0x00000000, 0x00000400, then o_trailer_done pulses 1 cycle later.
REQ-036 Build with TRAILER_CHUNK_LAYOUT_EN, chunk=1, layout=0x3 -> w1=0x00240000, w8=0x00000003, and the done pulse follows word 9.
REQ-037 Deassert i_ready for 3 cycles at w4 with status=0xA101 -> ov_data holds 0x0000A101 for 4 cycles, the total is still 8 accepted words, and no word is duplicated.
REQ-038 Drop i_stream_enable at w3 -> o_data_valid=0 on the next cycle, no done pulse, and the next start produces a complete trailer from w0.
REQ-039 Issue a second i_trailer_start during SEND and change iv_blockid mid-trailer -> the start is ignored and the words carry the originally latched values.
REQ-040 Assert reset at w5 -> all outputs are 0 on the next cycle and the FSM is in IDLE.
